// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite layer.
package sprite_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic in_box;
        logic blank;
    } tag_t;

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation step counter: advances anim_frame once every FRAME_PERIOD enabled frame_start pulses.
module sprite_anim_ctr #(
    parameter int unsigned FRAMES       = 4,
    parameter int unsigned FRAME_PERIOD = 8,
    parameter int unsigned FRAME_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               anim_en,
    output logic [FRAME_W-1:0] anim_frame
);

    localparam int unsigned TICK_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    always_comb begin
        tick_d  = tick_q;
        frame_d = frame_q;
        if (frame_start && anim_en) begin
            if (tick_q == TICK_W'(FRAME_PERIOD - 1)) begin
                tick_d  = '0;
                frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            tick_q  <= '0;
            frame_q <= '0;
        end else begin
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign anim_frame = frame_q;

endmodule

// File: rtl/sprite_layer_anim.sv
// Positioned, scaled, mirrored, animated sprite layer driving a 1-cycle synchronous sprite ROM.
module sprite_layer_anim
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W        = 70,
    parameter int unsigned SPR_H        = 70,
    parameter int unsigned FRAMES       = 4,
    parameter int unsigned FRAME_PERIOD = 8,
    parameter int unsigned SCALE_LOG2   = 0,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned TRANSP_IDX   = 0,
    localparam int unsigned ADDR_W      = $clog2(FRAMES * SPR_W * SPR_H),
    localparam int unsigned FRAME_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               frame_start,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               mirror,
    input  logic               anim_en,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pix_index,
    output logic               pix_valid,
    output logic [FRAME_W-1:0] anim_frame
);

    localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);

    coord_t pos_x_q, pos_y_q;
    logic   mirror_q;
    tag_t   tag1_q, tag2_q;

    logic [10:0]       rel_x, rel_y, lx, ly;
    logic              in_box;
    logic [ADDR_W-1:0] addr_d;

    sprite_anim_ctr #(
        .FRAMES      (FRAMES),
        .FRAME_PERIOD(FRAME_PERIOD),
        .FRAME_W     (FRAME_W)
    ) u_anim_ctr (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .anim_en    (anim_en),
        .anim_frame (anim_frame)
    );

    // Bit 10 of each 11-bit difference is the borrow: pixel lies left of / above the sprite.
    always_comb begin
        rel_x  = {1'b0, DrawX} - {1'b0, pos_x_q};
        rel_y  = {1'b0, DrawY} - {1'b0, pos_y_q};
        in_box = !rel_x[10] && !rel_y[10] && (rel_x < BOX_W) && (rel_y < BOX_H);
        lx     = rel_x >> SCALE_LOG2;
        if (mirror_q) begin
            lx = 11'(SPR_W - 1) - lx;
        end
        ly     = rel_y >> SCALE_LOG2;
        addr_d = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H)
               + ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx);
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            mirror_q    <= 1'b0;
            rom_address <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            pix_index   <= '0;
            pix_valid   <= 1'b0;
        end else begin
            if (frame_start) begin
                pos_x_q  <= pos_x;
                pos_y_q  <= pos_y;
                mirror_q <= mirror;
            end
            if (in_box) begin
                rom_address <= addr_d;
            end
            tag1_q    <= '{in_box: in_box, blank: blank};
            tag2_q    <= tag1_q;
            pix_index <= rom_q;
            pix_valid <= tag2_q.in_box & tag2_q.blank & (rom_q != IDX_W'(TRANSP_IDX));
        end
    end

endmodule

// File: tb/tb_sprite_layer_anim.sv
// Directed bench: instance A (FRAME_PERIOD=2, unscaled) and instance B (SCALE_LOG2=1) share stimulus.
module tb_sprite_layer_anim;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] draw_x, draw_y, pos_x, pos_y;
    logic       blank, frame_start, mirror, anim_en;
    logic [3:0] rom_val;

    logic [14:0] addr_a, addr_b, addr_a1, addr_b1;
    logic [3:0]  rom_q_a, rom_q_b, idx_a, idx_b;
    logic        valid_a, valid_b;
    logic [1:0]  frame_a, frame_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ROM models return the same programmable value at every address.
    always_ff @(posedge clk) begin
        rom_q_a <= rom_val;
        rom_q_b <= rom_val;
    end

    sprite_layer_anim #(.FRAME_PERIOD(2)) u_dut_a (
        .vga_clk    (clk),
        .reset_n    (reset_n),
        .DrawX      (draw_x),
        .DrawY      (draw_y),
        .blank      (blank),
        .frame_start(frame_start),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .mirror     (mirror),
        .anim_en    (anim_en),
        .rom_address(addr_a),
        .rom_q      (rom_q_a),
        .pix_index  (idx_a),
        .pix_valid  (valid_a),
        .anim_frame (frame_a)
    );

    sprite_layer_anim #(.SCALE_LOG2(1)) u_dut_b (
        .vga_clk    (clk),
        .reset_n    (reset_n),
        .DrawX      (draw_x),
        .DrawY      (draw_y),
        .blank      (blank),
        .frame_start(frame_start),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .mirror     (mirror),
        .anim_en    (anim_en),
        .rom_address(addr_b),
        .rom_q      (rom_q_b),
        .pix_index  (idx_b),
        .pix_valid  (valid_b),
        .anim_frame (frame_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    // Hold a pixel for 3 edges; address captured after edge 1, pix_* valid after edge 3.
    task automatic px(input logic [9:0] x, input logic [9:0] y, input logic b);
        draw_x = x;
        draw_y = y;
        blank  = b;
        step(1);
        addr_a1 = addr_a;
        addr_b1 = addr_b;
        step(2);
    endtask

    initial begin
        reset_n = 1'b0;
        draw_x = '0; draw_y = '0; blank = 1'b1; frame_start = 1'b0;
        pos_x = 10'd100; pos_y = 10'd50; mirror = 1'b0; anim_en = 1'b0;
        rom_val = 4'd5;
        step(2);
        check_eq("rst_addr", 32'(addr_a), 0);
        check_eq("rst_valid", 32'(valid_a), 0);
        check_eq("rst_frame", 32'(frame_a), 0);
        check_eq("rst_index", 32'(idx_a), 0);
        reset_n = 1'b1;
        pulse_fs();

        // Exact 3-edge latency on an out-of-box to in-box transition.
        px(10'd0, 10'd0, 1'b1);
        draw_x = 10'd100; draw_y = 10'd50;
        step(2);
        check_eq("lat_edge2", 32'(valid_a), 0);
        step(1);
        check_eq("lat_edge3", 32'(valid_a), 1);
        check_eq("lat_index", 32'(idx_a), 5);

        px(10'd169, 10'd50, 1'b1);
        check_eq("right_addr", 32'(addr_a1), 69);
        check_eq("right_valid", 32'(valid_a), 1);
        px(10'd170, 10'd50, 1'b1);
        check_eq("past_right", 32'(valid_a), 0);
        px(10'd99, 10'd50, 1'b1);
        check_eq("left_of", 32'(valid_a), 0);
        px(10'd100, 10'd119, 1'b1);
        check_eq("bottom_addr", 32'(addr_a1), 4830);
        check_eq("bottom_valid", 32'(valid_a), 1);
        px(10'd100, 10'd120, 1'b1);
        check_eq("past_bottom", 32'(valid_a), 0);
        px(10'd100, 10'd50, 1'b0);
        check_eq("blank_valid", 32'(valid_a), 0);
        check_eq("blank_addr", 32'(addr_a1), 0);

        mirror = 1'b1;
        pulse_fs();
        px(10'd100, 10'd50, 1'b1);
        check_eq("mir_left", 32'(addr_a1), 69);
        px(10'd169, 10'd50, 1'b1);
        check_eq("mir_right", 32'(addr_a1), 0);
        pos_x = 10'd300;
        px(10'd100, 10'd50, 1'b1);
        check_eq("shadow_addr", 32'(addr_a1), 69);
        check_eq("shadow_valid", 32'(valid_a), 1);
        pulse_fs();
        px(10'd100, 10'd50, 1'b1);
        check_eq("moved_old", 32'(valid_a), 0);
        px(10'd300, 10'd50, 1'b1);
        check_eq("moved_addr", 32'(addr_a1), 69);
        check_eq("moved_valid", 32'(valid_a), 1);
        mirror = 1'b0;
        pos_x  = 10'd100;
        pulse_fs();

        rom_val = 4'd0;
        px(10'd100, 10'd50, 1'b1);
        check_eq("transp_valid", 32'(valid_a), 0);
        check_eq("transp_index", 32'(idx_a), 0);
        rom_val = 4'd5;

        // Scaled instance.
        px(10'd239, 10'd50, 1'b1);
        check_eq("s_right_addr", 32'(addr_b1), 69);
        check_eq("s_right_valid", 32'(valid_b), 1);
        px(10'd101, 10'd50, 1'b1);
        check_eq("s_lx0_addr", 32'(addr_b1), 0);
        px(10'd240, 10'd50, 1'b1);
        check_eq("s_past_right", 32'(valid_b), 0);
        px(10'd100, 10'd189, 1'b1);
        check_eq("s_row69_addr", 32'(addr_b1), 4830);
        check_eq("s_row69_valid", 32'(valid_b), 1);
        px(10'd100, 10'd190, 1'b1);
        check_eq("s_past_bottom", 32'(valid_b), 0);
        pos_x = 10'd700;
        pulse_fs();
        px(10'd639, 10'd50, 1'b1);
        check_eq("off_a", 32'(valid_a), 0);
        check_eq("off_b", 32'(valid_b), 0);
        px(10'd0, 10'd50, 1'b1);
        check_eq("off_a_x0", 32'(valid_a), 0);
        pos_x = 10'd100;
        pulse_fs();

        // Animation: A steps every 2 pulses, B every 8.
        anim_en = 1'b1;
        pulse_fs();
        check_eq("anim_p1", 32'(frame_a), 0);
        pulse_fs();
        check_eq("anim_p2", 32'(frame_a), 1);
        check_eq("anim_b_p2", 32'(frame_b), 0);
        px(10'd100, 10'd50, 1'b1);
        check_eq("anim_addr", 32'(addr_a1), 4900);
        repeat (6) pulse_fs();
        check_eq("anim_wrap", 32'(frame_a), 0);
        check_eq("anim_b_p8", 32'(frame_b), 1);
        repeat (2) pulse_fs();
        check_eq("anim_p10", 32'(frame_a), 1);
        anim_en = 1'b0;
        repeat (3) pulse_fs();
        check_eq("hold_a", 32'(frame_a), 1);
        check_eq("hold_b", 32'(frame_b), 1);
        anim_en = 1'b1;
        pulse_fs();
        check_eq("resume_p1", 32'(frame_a), 1);
        pulse_fs();
        check_eq("resume_p2", 32'(frame_a), 2);
        anim_en = 1'b0;
        px(10'd100, 10'd50, 1'b1);
        check_eq("frame2_addr", 32'(addr_a1), 9800);
        check_eq("b_frame1_addr", 32'(addr_b1), 4900);

        // Mid-frame reset, then shadow position is (0,0) until the next frame_start.
        reset_n = 1'b0;
        step(1);
        check_eq("mrst_valid", 32'(valid_a), 0);
        check_eq("mrst_addr", 32'(addr_a), 0);
        check_eq("mrst_frame", 32'(frame_a), 0);
        step(1);
        reset_n = 1'b1;
        px(10'd69, 10'd0, 1'b1);
        check_eq("post_rst_addr", 32'(addr_a1), 69);
        check_eq("post_rst_valid", 32'(valid_a), 1);
        px(10'd70, 10'd0, 1'b1);
        check_eq("post_rst_edge", 32'(valid_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
